// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the core's memory port
// (CPU) and a program-loader/DMA port (DMA). The arbiter runs one transaction
// at a time against a variable-latency memory. Dual requests are granted
// round-robin. An access that never sees mem_ready is aborted after TIMEOUT
// ACCESS cycles and returns err.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   cpu_req/we/adr/wd -> cpu_rd/ack CPU request port, one-cycle ack
//   cpu_stall                       cpu_req & ~cpu_ack, holds the core's sequencer
//   dma_req/we/adr/wd -> dma_rd/ack DMA request port, one-cycle ack
//   mem_en/we/adr/wd, mem_rd/ready  memory side, ready completes the access
//   err                             completing transaction timed out (with ack)
//   busy                            FSM not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the granted port
// ACCESS | memory strobe active; waits for mem_ready or the wait limit
// RESP   | one-cycle ack (plus rd/err) to the owner; updates last_owner
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic [DW-1:0] dma_rd,
   output logic          dma_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   input  logic          mem_ready,
   output logic          err,
   output logic          busy
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // Last wait-counter value before the access is abandoned.
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic          owner;
   logic          last_owner;
   logic          we_q;
   logic          err_q;
   logic [AW-1:0] adr_q;
   logic [DW-1:0] wd_q;
   logic [DW-1:0] rd_q;
   logic [CW-1:0] wcnt;

   logic grant_dma;
   logic in_access;
   logic in_resp;

   // DMA wins when it is alone, or on a tie when the CPU was served last.
   always_comb begin
      grant_dma = dma_req & (~cpu_req | (last_owner == OWN_CPU));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         owner      <= OWN_CPU;
         last_owner <= OWN_DMA;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         adr_q      <= '0;
         wd_q       <= '0;
         rd_q       <= '0;
         wcnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_req | dma_req) begin
                  owner <= grant_dma ? OWN_DMA : OWN_CPU;
                  adr_q <= grant_dma ? dma_adr : cpu_adr;
                  we_q  <= grant_dma ? dma_we  : cpu_we;
                  wd_q  <= grant_dma ? dma_wd  : cpu_wd;
                  wcnt  <= '0;
                  state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  rd_q  <= mem_rd;
                  err_q <= 1'b0;
                  state <= S_RESP;
               end else if (wcnt == WAIT_LAST) begin
                  rd_q  <= '0;
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_RESP: begin
               last_owner <= owner;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_access = (state == S_ACCESS);
   assign in_resp   = (state == S_RESP);

   assign mem_en  = in_access;
   assign mem_we  = in_access & we_q;
   assign mem_adr = in_access ? adr_q : '0;
   assign mem_wd  = in_access ? wd_q  : '0;

   assign cpu_ack = in_resp & (owner == OWN_CPU);
   assign dma_ack = in_resp & (owner == OWN_DMA);
   assign cpu_rd  = cpu_ack ? rd_q : '0;
   assign dma_rd  = dma_ack ? rd_q : '0;
   assign err     = in_resp & err_q;
   assign busy    = (state != S_IDLE);

   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle ARM core between two requesters: the core's memory interface (CPU) and a program-loader/DMA port (DMA).
- Arbitrates between the two with round-robin priority, sequences one memory transaction at a time against a variable-latency memory (mem_ready), and returns read data with a one-cycle acknowledge.
- A wait-state counter aborts hung accesses with an error flag.
- The core's controller stalls its microsequencer on cpu_stall.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles without mem_ready before abort (must be >= 2)

Ports:
- clk  input  1  clock
- reset  input  1  reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  CPU write enable; 0 = read
- cpu_adr  input  AW  CPU byte address
- cpu_wd  input  DW  CPU write data
- cpu_rd  output  DW  CPU read data; valid only while cpu_ack=1
- cpu_ack  output  1  one-cycle CPU transaction complete
- cpu_stall  output  1  cpu_req & ~cpu_ack; gates the core's state advance
- dma_req  input  1  DMA access request; held until dma_ack
- dma_we  input  1  DMA write enable
- dma_adr  input  AW  DMA address
- dma_wd  input  DW  DMA write data
- dma_rd  output  DW  DMA read data; valid only while dma_ack=1
- dma_ack  output  1  one-cycle DMA transaction complete
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_adr  output  AW  memory address
- mem_wd  output  DW  memory write data
- mem_rd  input  DW  memory read data; valid when mem_ready=1
- mem_ready  input  1  memory completes the current access this cycle
- err  output  1  completing transaction timed out; valid with the ack
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset is clk/reset, asynchronous, active-high. Reset values: state=IDLE, last_owner=DMA (so CPU wins the first tie), all outputs 0, captured address/data/read registers 0, wait counter 0.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_owner.
  - On the grant edge, register owner, adr, we and wd from the granted port, clear the wait counter, and go to ACCESS.
  - The requester's inputs are sampled only at this edge; later changes are ignored.
- ACCESS:
  - mem_en=1. mem_we, mem_adr and mem_wd are driven from the registered values and are 0 in all other states.
  - mem_ready=1: capture mem_rd into the read register (for reads and writes alike), err<=0, go to RESP.
  - mem_ready=0 with wait counter == TIMEOUT-1: err<=1, read register<=0, go to RESP. No retry.
  - Otherwise: increment the wait counter and stay.
  - Wait counter width is clog2(TIMEOUT)+1; it never wraps.
- RESP:
  - Owner's ack=1 for exactly this cycle; the other port's ack=0.
  - Owner's rd = read register; the non-owner rd = 0.
  - err is driven from its register; err=0 outside RESP.
  - last_owner<=owner; go to IDLE unconditionally.
- Latency: request seen in IDLE at cycle N → mem_en in cycle N+1. With mem_ready in the first ACCESS cycle, ack is in cycle N+2, so the minimum is 3 cycles per transaction. Each wait state adds 1 cycle. A timeout yields ack at cycle N+TIMEOUT+1.
- Handshake:
  - A requester keeps req, we, adr and wd stable from assertion until it samples ack=1.
  - It may drop req in the cycle after ack.
  - req still high in the IDLE cycle after ack is a new request and is arbitrated normally.
- Fairness:
  - Continuous dual requests alternate CPU, DMA, CPU, …
  - A lone requester is granted back-to-back regardless of last_owner.
- A request arriving during ACCESS/RESP is not granted until the next IDLE.
- A request that drops before its grant is simply not served; there is no queueing.
- Reset mid-transaction: immediately return to IDLE with mem_en=0 and no ack. The aborted transaction is lost, and the requester re-issues it after reset.
- mem_ready outside ACCESS is ignored.
- cpu_stall is combinational from cpu_req and cpu_ack; no other combinational input-to-output paths exist.

Test Plan:
- Reset, then cpu_req=1 read of adr 0x20 with mem_ready high in the first ACCESS cycle and mem_rd=0xE04F000F → mem_en in cycle 2; cpu_ack=1 and cpu_rd=0xE04F000F in cycle 3; err=0; cpu_stall=1 in cycles 1-2 and 0 in cycle 3.
- DMA write adr 0x54, wd 0x12345678, with mem_ready delayed 3 cycles → mem_we=1 and mem_adr=0x54 held for 4 ACCESS cycles; dma_ack in the cycle after mem_ready; cpu_ack stays 0.
- cpu_req and dma_req both asserted together from reset and re-asserted after each ack for 4 transactions → grant order CPU, DMA, CPU, DMA; never two acks in one cycle.
- CPU read with mem_ready held 0 and TIMEOUT=16 → exactly 16 ACCESS cycles, then cpu_ack=1, err=1, cpu_rd=0. The next transaction (mem_ready=1) completes with err=0.
- Assert reset during the 2nd ACCESS cycle of a DMA read → mem_en drops immediately, no dma_ack, busy=0. After release, a pending cpu_req wins (last_owner=DMA) and completes normally.
- cpu_req left high for one cycle after cpu_ack with dma_req idle → a second CPU transaction starts with no idle gap beyond IDLE; cpu_adr change during its ACCESS does not alter mem_adr.
